period_meter: RTL
=================

Name: period_meter

Overview:
Measures an external square wave in clk cycles; the receive-side counterpart to the programmable tone counter.
- Takes an asynchronous input tone `sig_in`.
- Reports its period and high time as cycle counts, with a one-cycle valid strobe.
- Runs in single-shot or continuous mode, with a watchdog timeout for a missing or stalled input.
- Used for frequency self-check of the beep generator and for reading external frequency sources.

Parameters:
- CNT_W, 32, width of the period, high-time and watchdog counters.
- TIMEOUT, 50000000, watchdog limit in clk cycles for one measurement (1 s at 50 MHz); must be ≥ 4 and < 2^CNT_W.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-low reset.
- sig_in  input  1  measured signal, asynchronous to clk.
- mode  input  1  0 = single measurement, 1 = continuous; sampled on arming.
- meas_en  input  1  level enable. Rising edge arms single mode; high level sustains continuous mode.
- period_out  output  CNT_W  last measured period in clk cycles.
- high_out  output  CNT_W  last measured high time in clk cycles.
- meas_valid  output  1  one-cycle pulse when period_out and high_out update.
- busy  output  1  high in ARM or MEAS.
- timeout_flag  output  1  one-cycle pulse on watchdog expiry.

Behaviour:
- Reset: all outputs 0, FSM IDLE, all counters 0, synchronizer flops 0, stored mode 0.
- Input path: sig_in passes through 2 flops (s1, s2) plus a history flop s3.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - Input-to-edge-detect latency is 3 clk; the measured values do not depend on it.
- meas_en is registered once; en_rise = meas_en & ~meas_en_d.
- FSM states: IDLE, ARM, MEAS.
  - IDLE -> ARM when:
    - en_rise, or
    - meas_en high and mode = 1.
    - Store mode at this transition; clear the watchdog.
  - ARM -> MEAS on rise: pcnt <= 1, hcnt <= 1, clear watchdog.
  - MEAS, each cycle:
    - pcnt increments.
    - hcnt increments while s2 = 1 and no fall has yet been seen this period.
  - MEAS on rise (period complete):
    - period_out <= pcnt; high_out <= hcnt; meas_valid <= 1.
    - If stored mode = 1 and meas_en = 1: stay in MEAS with pcnt <= 1, hcnt <= 1, watchdog cleared. The same edge starts the next period, so there is no gap.
    - Otherwise: go to IDLE.
  - Period definition: for a sig_in period of N clk cycles, period_out = N. For high time H, high_out = H. Both counts are exact for a synchronous stimulus.
- Watchdog:
  - Counts every cycle in ARM and MEAS.
  - On reaching TIMEOUT-1 without a completing rise: timeout_flag <= 1 for one cycle, period_out <= 0, high_out <= 0, meas_valid stays 0.
  - Next state after expiry: ARM if stored mode = 1 and meas_en = 1; otherwise IDLE.
- Abort:
  - In continuous mode, meas_en = 0 in ARM or MEAS -> IDLE next cycle; no valid, outputs hold.
  - In single mode, meas_en falling does not abort.
- Input handling:
  - en_rise while busy is ignored.
  - Changing mode while busy has no effect until the next arming.
- Simultaneous events:
  - Completing rise and watchdog expiry in the same cycle: the rise wins (valid, no timeout).
  - rise and meas_en drop in the same cycle in continuous mode: the measurement is reported, then IDLE.
- Saturation: pcnt and hcnt saturate at all-ones; this is unreachable when TIMEOUT < 2^CNT_W.
- Output holding: period_out and high_out hold their last values until the next valid or timeout.
- busy = (state != IDLE), registered.
- Reset mid-measurement returns everything to reset values immediately; no valid or timeout pulse is generated.

Test Plan:
- Single mode, sig_in period 100 clk with 30 high, pulse meas_en -> exactly one meas_valid; period_out = 100, high_out = 30; busy then drops; no further valid.
- Continuous mode, meas_en held, period 20/high 10 for 5 periods -> 5 valid pulses spaced 20 clk apart, each 20/10. Then change to period 37/high 5 -> the next valid reports 37/5 with no lost period.
- sig_in held at 0, TIMEOUT = 1000, single mode -> timeout_flag at cycle 1000 after arming; period_out = 0, high_out = 0; FSM IDLE; meas_valid never asserted.
- Continuous mode, drop meas_en mid-period -> busy low next cycle; no valid; outputs keep the previous values. A second en_rise while busy (single mode) is ignored.
- Force a completing rise on the watchdog's final cycle -> meas_valid = 1, timeout_flag = 0.
- Assert rst low mid-MEAS -> all outputs 0 immediately. After release with meas_en low, FSM stays IDLE and ignores sig_in edges.

Source files
------------

// File: rtl/period_meter.sv
// period_meter: measures period and high time of an asynchronous square wave in clk cycles,
// single-shot or continuous, with a per-measurement watchdog.
module period_meter #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 50000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             mode,
  input  logic             meas_en,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             meas_valid,
  output logic             busy,
  output logic             timeout_flag
);
  typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  state_t           state_q, state_d;
  logic             s1_q, s2_q, s3_q, en_q;
  logic             mode_q, mode_d, fseen_q, fseen_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d, hcnt_q, hcnt_d, wd_q, wd_d;
  logic [CNT_W-1:0] period_q, period_d, high_q, high_d;
  logic             valid_q, valid_d, tout_q, tout_d, busy_q;
  logic             rise, fall, en_rise, cont, abort, wd_exp;
  assign rise    = s2_q & ~s3_q;
  assign fall    = ~s2_q & s3_q;
  assign en_rise = meas_en & ~en_q;
  assign cont    = mode_q & meas_en;
  assign abort   = mode_q & ~meas_en;
  assign wd_exp  = wd_q == WD_LAST;
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    fseen_d  = fseen_q;
    pcnt_d   = pcnt_q;
    hcnt_d   = hcnt_q;
    wd_d     = wd_q;
    period_d = period_q;
    high_d   = high_q;
    valid_d  = 1'b0;
    tout_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (en_rise || (meas_en && mode)) begin
          state_d = ARM;
          mode_d  = mode;
          wd_d    = '0;
        end
      end
      ARM: begin
        wd_d = wd_q + ONE;
        if (abort) begin
          state_d = IDLE;
        end else if (rise) begin
          state_d = MEAS;
          pcnt_d  = ONE;
          hcnt_d  = ONE;
          fseen_d = 1'b0;
          wd_d    = '0;
        end else if (wd_exp) begin
          state_d  = mode_q ? ARM : IDLE;
          tout_d   = 1'b1;
          period_d = '0;
          high_d   = '0;
          wd_d     = '0;
        end
      end
      MEAS: begin
        wd_d    = wd_q + ONE;
        pcnt_d  = &pcnt_q ? pcnt_q : pcnt_q + ONE;
        hcnt_d  = (s2_q && !fseen_q && !(&hcnt_q)) ? hcnt_q + ONE : hcnt_q;
        fseen_d = fseen_q | fall;
        // the completing rise wins over both abort and watchdog expiry
        if (rise) begin
          period_d = pcnt_q;
          high_d   = hcnt_q;
          valid_d  = 1'b1;
          state_d  = cont ? MEAS : IDLE;
          pcnt_d   = ONE;
          hcnt_d   = ONE;
          fseen_d  = 1'b0;
          wd_d     = '0;
        end else if (abort) begin
          state_d = IDLE;
        end else if (wd_exp) begin
          state_d  = mode_q ? ARM : IDLE;
          tout_d   = 1'b1;
          period_d = '0;
          high_d   = '0;
          wd_d     = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      en_q     <= 1'b0;
      mode_q   <= 1'b0;
      fseen_q  <= 1'b0;
      pcnt_q   <= '0;
      hcnt_q   <= '0;
      wd_q     <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      tout_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      s1_q     <= sig_in;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      en_q     <= meas_en;
      mode_q   <= mode_d;
      fseen_q  <= fseen_d;
      pcnt_q   <= pcnt_d;
      hcnt_q   <= hcnt_d;
      wd_q     <= wd_d;
      period_q <= period_d;
      high_q   <= high_d;
      valid_q  <= valid_d;
      tout_q   <= tout_d;
      busy_q   <= state_d != IDLE;
    end
  end
  assign period_out   = period_q;
  assign high_out     = high_q;
  assign meas_valid   = valid_q;
  assign timeout_flag = tout_q;
  assign busy         = busy_q;
endmodule
